// File: rtl/transc_pipe_pkg.sv
// rtl/transc_pipe_pkg.sv - shared constants and Hsu chroma mean/ratio LUT functions
package transc_pipe_pkg;

  localparam int K_L_DEFAULT = 125;
  localparam int K_H_DEFAULT = 188;
  localparam int Y_MIN       = 16;
  localparam int Y_MAX       = 235;

  localparam int MEAN_KH_CR  = 154;
  localparam int MEAN_KH_CB  = 108;

  // Cluster-centre offsets from MEAN_KH, reached at Ymin (low) and Ymax (high)
  localparam int MEAN_DLO_CR = -10;
  localparam int MEAN_DHI_CR = 22;
  localparam int MEAN_DLO_CB = 10;
  localparam int MEAN_DHI_CB = 10;

  // Cluster widths in hundredths: nominal, at Ymin, at Ymax
  localparam int W_CR  = 3876;
  localparam int WL_CR = 2000;
  localparam int WH_CR = 1000;
  localparam int W_CB  = 4697;
  localparam int WL_CB = 2300;
  localparam int WH_CB = 1400;

  function automatic int div_round(input int num, input int den);
    if (num >= 0) return (num + den / 2) / den;
    return -((-num + den / 2) / den);
  endfunction

  function automatic int clamp_y(input int y_in);
    if (y_in < Y_MIN) return Y_MIN;
    if (y_in > Y_MAX) return Y_MAX;
    return y_in;
  endfunction

  function automatic int mean_fp(input logic cb, input int y_in, input int kl,
                                 input int kh, input int frac);
    int y;
    int one;
    int base;
    int dlo;
    int dhi;
    y    = clamp_y(y_in);
    one  = 1 << frac;
    base = cb ? MEAN_KH_CB : MEAN_KH_CR;
    dlo  = cb ? MEAN_DLO_CB : MEAN_DLO_CR;
    dhi  = cb ? MEAN_DHI_CB : MEAN_DHI_CR;
    if (y < kl) return base * one + div_round((kl - y) * dlo * one, kl - Y_MIN);
    if (y > kh) return base * one + div_round((y - kh) * dhi * one, Y_MAX - kh);
    return base * one;
  endfunction

  function automatic int ratio_fp(input logic cb, input int y_in, input int kl,
                                  input int kh, input int frac);
    int y;
    int one;
    int wc;
    int wl;
    int wh;
    y   = clamp_y(y_in);
    one = 1 << frac;
    wc  = cb ? W_CB : W_CR;
    wl  = cb ? WL_CB : WL_CR;
    wh  = cb ? WH_CB : WH_CR;
    if (y < kl)
      return div_round(wc * one * (kl - Y_MIN), wl * (kl - Y_MIN) + (y - Y_MIN) * (wc - wl));
    if (y > kh)
      return div_round(wc * one * (Y_MAX - kh), wh * (Y_MAX - kh) + (Y_MAX - y) * (wc - wh));
    return one;
  endfunction

endpackage

// File: rtl/transc_pipe_fp_mult.sv
// rtl/transc_pipe_fp_mult.sv - signed fixed-point multiply, product shifted right by FRAC
module fp_mult #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 6
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] p
);

  logic signed [2*WIDTH-1:0] a_x;
  logic signed [2*WIDTH-1:0] b_x;
  logic signed [2*WIDTH-1:0] full;

  assign a_x  = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_x  = {{WIDTH{b[WIDTH-1]}}, b};
  assign full = a_x * b_x;
  assign p    = WIDTH'(full >>> FRAC);

endmodule

// File: rtl/transc_pipe.sv
// rtl/transc_pipe.sv - 5-stage Hsu nonlinear chroma transform with luma bypass window
module transc_pipe
  import transc_pipe_pkg::*;
#(
  parameter int FP_WIDTH  = 16,
  parameter int FRAC_BITS = 6,
  parameter int OUT_WIDTH = 8,
  parameter int K_L       = K_L_DEFAULT,
  parameter int K_H       = K_H_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 sel_cb,
  input  logic [7:0]           y,
  input  logic [7:0]           c,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_c,
  output logic                 out_sel_cb
);

  typedef logic signed [FP_WIDTH-1:0] fp_t;

  localparam fp_t MEAN_KH_CR_FP = fp_t'(MEAN_KH_CR << FRAC_BITS);
  localparam fp_t MEAN_KH_CB_FP = fp_t'(MEAN_KH_CB << FRAC_BITS);
  localparam fp_t SAT_MAX       = fp_t'((1 << OUT_WIDTH) - 1);

  // Index 0 = Cr, 1 = Cb; tables fold to constants at elaboration
  fp_t mean_rom  [2][256];
  fp_t ratio_rom [2][256];

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    for (genvar yi = 0; yi < 256; yi++) begin : g_y
      assign mean_rom[ch][yi]  = fp_t'(mean_fp(ch == 1, yi, K_L, K_H, FRAC_BITS));
      assign ratio_rom[ch][yi] = fp_t'(ratio_fp(ch == 1, yi, K_L, K_H, FRAC_BITS));
    end
  end

  logic adv;
  assign adv      = out_ready || !out_valid;
  assign in_ready = adv;

  int   y_int;
  logic in_byp;
  assign y_int  = int'(y);
  assign in_byp = (y_int >= K_L) && (y_int <= K_H);

  // Sideband shift chain, index = stage number
  logic [4:1] vld;
  logic [4:1] sel_q;
  logic [4:1] byp_q;
  logic [7:0] c_q [1:4];

  fp_t mean1;
  fp_t ratio1;
  fp_t d2;
  fp_t ratio2;
  fp_t m3;
  fp_t a4;
  fp_t prod;

  fp_mult #(
    .WIDTH (FP_WIDTH),
    .FRAC  (FRAC_BITS)
  ) u_fp_mult (
    .a (d2),
    .b (ratio2),
    .p (prod)
  );

  fp_t                 a_floor;
  logic [OUT_WIDTH-1:0] sat;

  assign a_floor = a4 >>> FRAC_BITS;

  always_comb begin
    if (a4[FP_WIDTH-1])
      sat = '0;
    else if (a_floor > SAT_MAX)
      sat = '1;
    else
      sat = a_floor[OUT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld        <= '0;
      out_valid  <= 1'b0;
      out_c      <= '0;
      out_sel_cb <= 1'b0;
    end else if (adv) begin
      vld        <= {vld[3:1], in_valid};
      out_valid  <= vld[4];
      out_c      <= byp_q[4] ? OUT_WIDTH'(c_q[4]) : sat;
      out_sel_cb <= sel_q[4];
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      sel_q  <= {sel_q[3:1], sel_cb};
      byp_q  <= {byp_q[3:1], in_byp};
      c_q[1] <= c;
      for (int i = 2; i <= 4; i++) c_q[i] <= c_q[i-1];

      mean1  <= mean_rom[sel_cb][y];
      ratio1 <= ratio_rom[sel_cb][y];
      d2     <= (fp_t'(c_q[1]) <<< FRAC_BITS) - mean1;
      ratio2 <= ratio1;
      m3     <= prod;
      a4     <= m3 + (sel_q[3] ? MEAN_KH_CB_FP : MEAN_KH_CR_FP);
    end
  end

endmodule

// File: tb/tb_transc_pipe.sv
// tb/tb_transc_pipe.sv - directed self-checking bench for transc_pipe
module tb_transc_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       sel_cb;
  logic [7:0] y;
  logic [7:0] c;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_c;
  logic       out_sel_cb;

  int vectors = 0;
  int errors  = 0;

  localparam logic       BP_SEL [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic [7:0] BP_Y   [8] = '{8'd150, 8'd150, 8'd16, 8'd16, 8'd150, 8'd150, 8'd16, 8'd130};
  localparam logic [7:0] BP_C   [8] = '{8'd20, 8'd21, 8'd144, 8'd118, 8'd24, 8'd25, 8'd255, 8'd27};
  localparam logic [7:0] BP_EXP [8] = '{8'd20, 8'd21, 8'd154, 8'd108, 8'd24, 8'd25, 8'd255, 8'd27};

  transc_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sel_cb     (sel_cb),
    .y          (y),
    .c          (c),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_c      (out_c),
    .out_sel_cb (out_sel_cb)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Presents one sample, then waits (bounded) for it to emerge with out_ready high
  task automatic run_one(input logic s, input logic [7:0] yy, input logic [7:0] cc,
                         output int lat, output logic [7:0] oc, output logic os);
    sel_cb    = s;
    y         = yy;
    c         = cc;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    oc = out_c;
    os = out_sel_cb;
  endtask

  task automatic vec_eq(input string tag, input logic s, input logic [7:0] yy,
                        input logic [7:0] cc, input logic [7:0] exp_c);
    int         lat;
    logic [7:0] oc;
    logic       os;
    run_one(s, yy, cc, lat, oc, os);
    check({tag, "_latency"}, lat, 5);
    check({tag, "_out_c"}, oc, exp_c);
    check({tag, "_sel"}, os, s);
  endtask

  task automatic vec_ne(input string tag, input logic s, input logic [7:0] yy,
                        input logic [7:0] cc, input logic [7:0] not_c);
    int         lat;
    logic [7:0] oc;
    logic       os;
    run_one(s, yy, cc, lat, oc, os);
    check({tag, "_latency"}, lat, 5);
    check({tag, "_transformed"}, oc != not_c, 1);
    check({tag, "_sel"}, os, s);
  endtask

  initial begin
    int   rx;
    int   nx;
    logic acc;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sel_cb    = 1'b0;
    y         = 8'd0;
    c         = 8'd0;
    @(negedge clk);
    step();
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_c", out_c, 0);
    check("rst_out_sel", out_sel_cb, 0);
    check("rst_in_ready", in_ready, 1);

    rst = 1'b0;
    vec_eq("cr_y16_c144", 1'b0, 8'd16, 8'd144, 8'd154);
    vec_eq("cb_y16_c118", 1'b1, 8'd16, 8'd118, 8'd108);
    vec_ne("cb_y124", 1'b1, 8'd124, 8'd200, 8'd200);
    vec_eq("cb_y125", 1'b1, 8'd125, 8'd200, 8'd200);
    vec_eq("cb_y188", 1'b1, 8'd188, 8'd200, 8'd200);
    vec_ne("cb_y189", 1'b1, 8'd189, 8'd200, 8'd200);
    vec_eq("cr_y125", 1'b0, 8'd125, 8'd200, 8'd200);
    vec_eq("cr_sat_hi", 1'b0, 8'd16, 8'd255, 8'd255);
    vec_eq("cr_sat_lo", 1'b0, 8'd16, 8'd0, 8'd0);
    step();
    check("drain_idle", out_valid, 0);

    // Back-pressure: 8 back-to-back samples, out_ready low in cycles 6-9
    rx = 0;
    nx = 0;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      out_ready = !(cyc >= 6 && cyc <= 9);
      if (nx < 8) begin
        in_valid = 1'b1;
        sel_cb   = BP_SEL[nx];
        y        = BP_Y[nx];
        c        = BP_C[nx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      check("bp_in_ready", in_ready, (cyc >= 6 && cyc <= 9) ? 0 : 1);
      if (cyc >= 6 && cyc <= 9) begin
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_c", out_c, BP_EXP[0]);
        check("bp_hold_sel", out_sel_cb, BP_SEL[0]);
      end
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        check("bp_no_dup", rx < 8, 1);
        if (rx < 8) begin
          check("bp_out_c", out_c, BP_EXP[rx]);
          check("bp_out_sel", out_sel_cb, BP_SEL[rx]);
          rx++;
        end
      end
      @(posedge clk);
      if (acc) nx++;
      @(negedge clk);
    end
    check("bp_received", rx, 8);
    check("bp_sent", nx, 8);

    // Reset with three samples in flight, plus one presented during reset
    out_ready = 1'b1;
    in_valid  = 1'b1;
    sel_cb    = 1'b0;
    y         = 8'd16;
    c         = 8'd144;
    for (int i = 0; i < 3; i++) step();
    rst = 1'b1;
    c   = 8'd0;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    step();
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_c", out_c, 0);
    rst = 1'b0;
    vec_eq("post_rst", 1'b0, 8'd16, 8'd144, 8'd154);
    for (int i = 0; i < 6; i++) begin
      step();
      check("post_rst_no_stale", out_valid, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/transc_pipe.md
TRANSC_PIPE -- requirements
Module: transc_pipe

Interface
REQ-001 SHALL have parameter FP_WIDTH, default 16, signed fixed-point datapath width.
REQ-002 SHALL have parameter FRAC_BITS, default 6, fractional bits of the datapath format.
REQ-003 SHALL have parameter OUT_WIDTH, default 8, output sample width.
REQ-004 SHALL have parameters K_L, default 125, and K_H, default 188, the luma bypass window bounds (inclusive).
REQ-005 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-006 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports: in_valid  in  1  input sample present.
REQ-008 SHALL have ports: in_ready  out  1  input accepted when in_valid&&in_ready.
REQ-009 SHALL have ports: sel_cb  in  1  per-sample mode, 1 = Cb channel, 0 = Cr channel.
REQ-010 SHALL have ports: y  in  8  luma; c  in  8  chroma (Cb or Cr per sel_cb).
REQ-011 SHALL have ports: out_valid  out  1; out_ready  in  1; out_c  out  OUT_WIDTH  transformed chroma; out_sel_cb  out  1  echoed mode.

Function
REQ-012 SHALL advance the whole pipeline on a rising edge only when adv = out_ready || !out_valid; in_ready SHALL equal adv combinationally.
REQ-013 SHALL hold every stage register, including out_c, out_valid, and out_sel_cb, unchanged while adv = 0.
REQ-014 SHALL have a latency of exactly 5 advancing edges from acceptance to out_valid = 1, sustaining one sample per cycle when out_ready is held at 1.
REQ-015 SHALL carry a valid bit, sel_cb, c, and the bypass flag alongside every stage; bubbles (valid = 0) SHALL propagate and never assert out_valid.
REQ-016 SHALL compute the bypass flag from the accepted sample's own y: bypass = (K_L <= y <= K_H).
REQ-017 Stage 1 SHALL register the channel-selected mean(y) and ratio(y) LUT outputs in FP format.
REQ-018 Stage 2 SHALL compute d = (c << FRAC_BITS) - mean(y), signed FP_WIDTH.
REQ-019 Stage 3 SHALL compute m = (d * ratio(y)) >>> FRAC_BITS, truncated to FP_WIDTH.
REQ-020 Stage 4 SHALL compute a = m + MEAN_KH(sel), where MEAN_KH is 154 for Cr and 108 for Cb, in FP format.
REQ-021 Stage 5 SHALL output out_c = c when bypass, else floor(a) clamped to [0, 2^OUT_WIDTH - 1].
REQ-022 LUTs SHALL follow the piecewise Hsu mean and width model for Y < K_L and Y > K_H (Ymin = 16, Ymax = 235).
REQ-023 The mean LUTs SHALL satisfy mean_cr(16) = 144 and mean_cb(16) = 118.
REQ-024 The ratio LUTs SHALL satisfy ratio = Wc / Wc(y), with ratio_cr(16) = 38.76 / 20 and ratio_cb(16) = 46.97 / 23, quantised to FRAC_BITS.
REQ-025 LUT output for y inside the bypass window SHALL be don't-care, since it is masked by bypass.
REQ-026 Mixed sel_cb across consecutive samples SHALL be processed independently, with no cross-sample state.

Reset
REQ-027 While rst = 1, all valid bits, out_valid, out_c, and out_sel_cb SHALL be cleared to 0 on each rising edge.
REQ-028 Reset SHALL take priority over adv, and in-flight samples SHALL be discarded.
REQ-029 in_ready SHALL follow REQ-012 during reset, and samples presented during reset SHALL be dropped.
REQ-030 The first edge after rst deasserts SHALL accept input normally.

Structure
REQ-031 A shared package SHALL hold K_L/K_H defaults, the MEAN_KH constants, Ymin/Ymax, and the mean/ratio LUT functions for both channels.
REQ-032 The existing fp_mult SHALL be instantiated as the sole sub-module, for stage 3.
REQ-033 The stage pipeline SHALL be written as a generic valid/stall shift chain with no FSM beyond the valid bits.

Verification
REQ-034 SHALL verify Cr, y=16, c=144, out_ready=1 -> out_c=154, out_sel_cb=0, out_valid exactly 5 cycles after acceptance.
REQ-035 SHALL verify Cb, y=16, c=118 -> out_c=108, out_sel_cb=1.
REQ-036 SHALL verify the window boundary: y=124, c=200 transformed (out_c != 200); y=125 and y=188, c=200 -> out_c=200; y=189 transformed.
REQ-037 SHALL verify saturation: Cr, y=16, c=255 -> out_c=255 (unclamped about 369); Cr, y=16, c=0 -> out_c=0.
REQ-038 SHALL verify back-pressure: 8 back-to-back samples with out_ready low for cycles 6-9 -> no loss or duplication, in_ready=0 in those cycles, order preserved, outputs stable while stalled.
REQ-039 SHALL verify reset: rst asserted for 1 cycle with 3 samples in flight -> out_valid=0 next cycle, no stale outputs afterward, and a new sample accepted on the first edge after release.
